// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg
//   Shared definitions for the SPI bus arbiter. It holds the FSM state
//   enumeration, the requester indices and the idle chip-select pattern.
//   It also provides a helper that sizes the burst-timing counter.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } arb_state_e;

  localparam int         REQ_DISPLAY  = 0;
  localparam int         REQ_KEYBOARD = 1;
  localparam logic [1:0] CS_IDLE      = 2'b11;

  // Largest of the three CS timing values; used to size the shared counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return m;
  endfunction

endpackage

// File: rtl/spi_rr_pick.sv
// spi_rr_pick
//   Two-way round-robin winner selection. A lone requester always wins.
//   On a tie, the requester that was not granted last wins. The last-grant
//   register resets to 1, so requester 0 wins the first tie after reset.
// Ports:
//   i_Clk, i_Rst_L  clock, asynchronous active-low reset
//   i_Req           per-requester request
//   i_Update        load i_Update_Idx into last-grant (end of a burst)
//   i_Update_Idx    index of the requester whose burst just ended
//   o_Valid         at least one requester is asking
//   o_Win           one-hot winner, 2'b00 when nobody asks
module spi_rr_pick
  import spi_arb_pkg::*;
(
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [1:0] i_Req,
  input  logic       i_Update,
  input  logic       i_Update_Idx,
  output logic       o_Valid,
  output logic [1:0] o_Win
);

  logic last_q;

  // Winner decode from the live requests and the last owner.
  always_comb begin
    o_Win = 2'b00;
    case (i_Req)
      2'b01:   o_Win = 2'b01;
      2'b10:   o_Win = 2'b10;
      2'b11:   o_Win = last_q ? 2'b01 : 2'b10;
      default: o_Win = 2'b00;
    endcase
    o_Valid = |i_Req;
  end

  // Last-grant register. It changes only when a burst closes.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      last_q <= 1'b1;
    end else if (i_Update) begin
      last_q <= i_Update_Idx;
    end else begin
      last_q <= last_q;
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter
//   Shares one SPI_Master between requester 0 (the display streamer) and
//   requester 1 (the keyboard reader). Each grant is a chip-select-framed
//   burst: SETUP, then XFER, then HOLD, then GAP. During XFER the owner may
//   pass one byte at a time to the master. The next byte is blocked until
//   the master's receive strobe for the byte in flight has been seen.
// Ports:
//   i_Clk, i_Rst_L            clock, asynchronous active-low reset
//   i_Req/i_DV                per-requester request and byte strobe
//   i_Byte_n/i_DC_n           requester byte and D/C, sampled on i_DV
//   o_Grant/o_Byte_Ready      one-hot owner and "may strobe now"
//   o_RX_Byte/o_RX_DV         received byte, strobed to the owner only
//   o_TX_Byte/o_TX_DV         to SPI_Master
//   i_TX_Ready/i_RX_DV/i_RX_Byte  from SPI_Master
//   o_CS_L/o_DC               active-low chip selects, D/C of byte in flight
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int CS_SETUP_CLKS = 2,
  parameter int CS_HOLD_CLKS  = 2,
  parameter int CS_GAP_CLKS   = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [1:0] i_Req,
  input  logic [1:0] i_DV,
  input  logic [7:0] i_Byte_0,
  input  logic [7:0] i_Byte_1,
  input  logic       i_DC_0,
  input  logic       i_DC_1,
  output logic [1:0] o_Grant,
  output logic [1:0] o_Byte_Ready,
  output logic [7:0] o_RX_Byte,
  output logic [1:0] o_RX_DV,
  output logic [7:0] o_TX_Byte,
  output logic       o_TX_DV,
  input  logic       i_TX_Ready,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic [1:0] o_CS_L,
  output logic       o_DC
);

  localparam int CNT_W = $clog2(max3(CS_SETUP_CLKS, CS_HOLD_CLKS, CS_GAP_CLKS) + 1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP_CLKS);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CS_HOLD_CLKS);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(CS_GAP_CLKS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  arb_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       grant_q;
  logic [1:0]       cs_q;
  logic             pending_q;
  logic [7:0]       tx_byte_q;
  logic             tx_dv_q;
  logic             dc_q;
  logic [7:0]       rx_byte_q;
  logic [1:0]       rx_dv_q;

  logic             win_valid_s;
  logic [1:0]       win_s;
  logic             hold_done_s;
  logic [1:0]       ready_s;
  logic             accept_s;
  logic             owner_req_s;
  logic [7:0]       sel_byte_s;
  logic             sel_dc_s;

  // A count of 1 means the current cycle is the last one in a timed state.
  assign hold_done_s = (state_q == ST_HOLD) && (cnt_q == CNT_ONE);

  spi_rr_pick u_pick (
    .i_Clk        (i_Clk),
    .i_Rst_L      (i_Rst_L),
    .i_Req        (i_Req),
    .i_Update     (hold_done_s),
    .i_Update_Idx (grant_q[REQ_KEYBOARD]),
    .o_Valid      (win_valid_s),
    .o_Win        (win_s)
  );

  // Byte pacing. Only the owner sees ready. Ready is low while a byte
  // waits for the master's receive strobe.
  always_comb begin
    if ((state_q == ST_XFER) && i_TX_Ready && !pending_q) begin
      ready_s = grant_q;
    end else begin
      ready_s = 2'b00;
    end
    accept_s    = |(ready_s & i_DV);
    owner_req_s = |(grant_q & i_Req);
  end

  // Select the owner's byte and D/C.
  always_comb begin
    if (grant_q[REQ_KEYBOARD]) begin
      sel_byte_s = i_Byte_1;
      sel_dc_s   = i_DC_1;
    end else begin
      sel_byte_s = i_Byte_0;
      sel_dc_s   = i_DC_0;
    end
  end

  // Burst FSM, the timing counter, the pending flag and all registered
  // outputs. Each timed state loaded with k lasts exactly k cycles.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      grant_q   <= 2'b00;
      cs_q      <= CS_IDLE;
      pending_q <= 1'b0;
      tx_byte_q <= 8'h00;
      tx_dv_q   <= 1'b0;
      dc_q      <= 1'b0;
      rx_byte_q <= 8'h00;
      rx_dv_q   <= 2'b00;
    end else begin
      tx_dv_q <= 1'b0;
      rx_dv_q <= 2'b00;
      if ((state_q == ST_XFER) && i_RX_DV) begin
        rx_byte_q <= i_RX_Byte;
        rx_dv_q   <= grant_q;
      end
      case (state_q)
        ST_IDLE: begin
          if (win_valid_s) begin
            grant_q <= win_s;
            cs_q    <= ~win_s;
            cnt_q   <= SETUP_LD;
            state_q <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_q <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (accept_s) begin
            tx_byte_q <= sel_byte_s;
            dc_q      <= sel_dc_s;
            tx_dv_q   <= 1'b1;
            pending_q <= 1'b1;
          end else if (i_RX_DV) begin
            pending_q <= 1'b0;
          end else if (!owner_req_s && !pending_q) begin
            cnt_q   <= HOLD_LD;
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          cnt_q <= cnt_q - CNT_ONE;
          if (hold_done_s) begin
            cs_q    <= CS_IDLE;
            grant_q <= 2'b00;
            cnt_q   <= GAP_LD;
            state_q <= ST_GAP;
          end
        end
        ST_GAP: begin
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          grant_q   <= 2'b00;
          cs_q      <= CS_IDLE;
          pending_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_Grant      = grant_q;
  assign o_Byte_Ready = ready_s;
  assign o_RX_Byte    = rx_byte_q;
  assign o_RX_DV      = rx_dv_q;
  assign o_TX_Byte    = tx_byte_q;
  assign o_TX_DV      = tx_dv_q;
  assign o_CS_L       = cs_q;
  assign o_DC         = dc_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed self-checking bench for spi_bus_arbiter with CS timing 2/2/2.
// Inputs change on the falling edge. Outputs are sampled on the falling edge.
module tb_spi_bus_arbiter;

  logic       i_Clk = 1'b0;
  logic       i_Rst_L;
  logic [1:0] i_Req;
  logic [1:0] i_DV;
  logic [7:0] i_Byte_0, i_Byte_1;
  logic       i_DC_0, i_DC_1;
  logic [1:0] o_Grant, o_Byte_Ready, o_RX_DV, o_CS_L;
  logic [7:0] o_RX_Byte, o_TX_Byte, i_RX_Byte;
  logic       o_TX_DV, i_TX_Ready, i_RX_DV, o_DC;

  int n_checks = 0;
  int n_errors = 0;
  int rx0_pulses = 0;
  int rx0_before;

  spi_bus_arbiter #(
    .CS_SETUP_CLKS (2),
    .CS_HOLD_CLKS  (2),
    .CS_GAP_CLKS   (2)
  ) dut (
    .i_Clk        (i_Clk),
    .i_Rst_L      (i_Rst_L),
    .i_Req        (i_Req),
    .i_DV         (i_DV),
    .i_Byte_0     (i_Byte_0),
    .i_Byte_1     (i_Byte_1),
    .i_DC_0       (i_DC_0),
    .i_DC_1       (i_DC_1),
    .o_Grant      (o_Grant),
    .o_Byte_Ready (o_Byte_Ready),
    .o_RX_Byte    (o_RX_Byte),
    .o_RX_DV      (o_RX_DV),
    .o_TX_Byte    (o_TX_Byte),
    .o_TX_DV      (o_TX_DV),
    .i_TX_Ready   (i_TX_Ready),
    .i_RX_DV      (i_RX_DV),
    .i_RX_Byte    (i_RX_Byte),
    .o_CS_L       (o_CS_L),
    .o_DC         (o_DC)
  );

  always #5 i_Clk = ~i_Clk;

  // Counts receive strobes routed to requester 0.
  always @(negedge i_Clk) begin
    if (o_RX_DV[0]) rx0_pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_Clk);
    @(negedge i_Clk);
  endtask

  task automatic do_reset();
    i_Rst_L   = 1'b0;
    i_Req     = 2'b00;
    i_DV      = 2'b00;
    i_RX_DV   = 1'b0;
    tick();
    tick();
    i_Rst_L   = 1'b1;
  endtask

  task automatic wait_grant(input logic [1:0] exp, input int budget, input string tag);
    int n;
    n = 0;
    while (o_Grant !== exp && n < budget) begin
      tick();
      n++;
    end
    chk(tag, o_Grant, exp);
  endtask

  // One full byte: owner strobes, bench checks the TX side, then the bench
  // plays the master's receive strobe and checks the routed RX side.
  task automatic send_byte(input int idx, input logic [7:0] b, input logic dc,
                           input logic [7:0] rx, input string tag);
    logic [1:0] oh;
    logic [1:0] cs_exp;
    oh     = (idx == 1) ? 2'b10 : 2'b01;
    cs_exp = ~oh;
    chk({tag, "_ready"}, o_Byte_Ready, oh);
    i_DV = oh;
    if (idx == 1) begin
      i_Byte_1 = b;
      i_DC_1   = dc;
    end else begin
      i_Byte_0 = b;
      i_DC_0   = dc;
    end
    tick();
    i_DV = 2'b00;
    chk({tag, "_txdv"}, o_TX_DV, 1'b1);
    chk({tag, "_txbyte"}, o_TX_Byte, b);
    chk({tag, "_dc"}, o_DC, dc);
    chk({tag, "_cs"}, o_CS_L, cs_exp);
    chk({tag, "_busy"}, o_Byte_Ready, 2'b00);
    i_RX_DV   = 1'b1;
    i_RX_Byte = rx;
    tick();
    i_RX_DV   = 1'b0;
    chk({tag, "_txdv_off"}, o_TX_DV, 1'b0);
    chk({tag, "_rxdv"}, o_RX_DV, oh);
    chk({tag, "_rxbyte"}, o_RX_Byte, rx);
    chk({tag, "_ready2"}, o_Byte_Ready, oh);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_Rst_L = 1'b0; i_Req = 2'b00; i_DV = 2'b00;
    i_Byte_0 = 8'h00; i_Byte_1 = 8'h00; i_DC_0 = 1'b0; i_DC_1 = 1'b0;
    i_TX_Ready = 1'b1; i_RX_DV = 1'b0; i_RX_Byte = 8'h00;
    tick();
    // Reset state
    chk("rst_cs", o_CS_L, 2'b11);
    chk("rst_grant", o_Grant, 2'b00);
    chk("rst_ready", o_Byte_Ready, 2'b00);
    chk("rst_txdv", o_TX_DV, 1'b0);
    chk("rst_txbyte", o_TX_Byte, 8'h00);
    chk("rst_dc", o_DC, 1'b0);
    chk("rst_rxbyte", o_RX_Byte, 8'h00);
    chk("rst_rxdv", o_RX_DV, 2'b00);
    i_Rst_L = 1'b1;

    // Burst of three bytes from requester 0, exact SETUP/HOLD spacing
    i_Req = 2'b01;
    tick();
    chk("t1_grant", o_Grant, 2'b01);
    chk("t1_cs", o_CS_L, 2'b10);
    chk("t1_setup1", o_Byte_Ready, 2'b00);
    tick();
    chk("t1_setup2", o_Byte_Ready, 2'b00);
    tick();
    send_byte(0, 8'hAE, 1'b0, 8'h01, "t1_b0");
    send_byte(0, 8'hD5, 1'b0, 8'h02, "t1_b1");
    send_byte(0, 8'h80, 1'b0, 8'h03, "t1_b2");
    i_Req = 2'b00;
    tick();
    chk("t1_hold1_cs", o_CS_L, 2'b10);
    tick();
    chk("t1_hold2_cs", o_CS_L, 2'b10);
    tick();
    chk("t1_end_cs", o_CS_L, 2'b11);
    chk("t1_end_grant", o_Grant, 2'b00);

    // Tie after reset: requester 0 first, then requester 1 after the gap
    do_reset();
    i_Req = 2'b11;
    tick();
    chk("t2_grant0", o_Grant, 2'b01);
    chk("t2_cs0", o_CS_L, 2'b10);
    tick();
    tick();
    send_byte(0, 8'h11, 1'b0, 8'h22, "t2_b0");
    i_Req = 2'b10;
    tick();
    tick();
    tick();
    chk("t2_gap_cs", o_CS_L, 2'b11);
    chk("t2_gap_grant", o_Grant, 2'b00);
    tick();
    chk("t2_gap2_grant", o_Grant, 2'b00);
    tick();
    chk("t2_idle_grant", o_Grant, 2'b00);
    tick();
    chk("t2_grant1", o_Grant, 2'b10);
    chk("t2_cs1", o_CS_L, 2'b01);

    // Requester 1 owns: foreign strobe ignored, RX routed only to owner
    rx0_before = rx0_pulses;
    tick();
    tick();
    chk("t4_ready1", o_Byte_Ready, 2'b10);
    i_DV = 2'b01; i_Byte_0 = 8'hEE; i_DC_0 = 1'b1;
    tick();
    i_DV = 2'b00;
    chk("t4_foreign_txdv", o_TX_DV, 1'b0);
    chk("t4_foreign_txbyte", o_TX_Byte, 8'h11);
    i_DV = 2'b10; i_Byte_1 = 8'h5A; i_DC_1 = 1'b1;
    tick();
    i_DV = 2'b00;
    chk("t3_txdv", o_TX_DV, 1'b1);
    chk("t3_txbyte", o_TX_Byte, 8'h5A);
    chk("t3_dc", o_DC, 1'b1);
    chk("t4_busy_ready", o_Byte_Ready, 2'b00);
    i_DV = 2'b10; i_Byte_1 = 8'hFF; i_DC_1 = 1'b0;
    tick();
    i_DV = 2'b00;
    chk("t4_busy_txdv", o_TX_DV, 1'b0);
    chk("t4_busy_txbyte", o_TX_Byte, 8'h5A);
    chk("t4_dc_kept", o_DC, 1'b1);
    i_RX_DV = 1'b1; i_RX_Byte = 8'h42;
    tick();
    i_RX_DV = 1'b0;
    chk("t3_rxdv", o_RX_DV, 2'b10);
    chk("t3_rxbyte", o_RX_Byte, 8'h42);
    tick();
    chk("t3_rxdv_once", o_RX_DV, 2'b00);
    chk("t3_rx0_never", rx0_pulses - rx0_before, 0);

    // Requester 1 drops request with a byte pending
    i_DV = 2'b10; i_Byte_1 = 8'h33; i_DC_1 = 1'b0;
    tick();
    i_DV = 2'b00;
    chk("t5_txbyte", o_TX_Byte, 8'h33);
    chk("t5_dc", o_DC, 1'b0);
    i_Req = 2'b00;
    tick();
    chk("t5_wait1_cs", o_CS_L, 2'b01);
    tick();
    chk("t5_wait2_cs", o_CS_L, 2'b01);
    i_RX_DV = 1'b1; i_RX_Byte = 8'h99;
    tick();
    i_RX_DV = 1'b0;
    chk("t5_rx_cs", o_CS_L, 2'b01);
    chk("t5_rxbyte", o_RX_Byte, 8'h99);
    tick();
    chk("t5_hold1_cs", o_CS_L, 2'b01);
    tick();
    chk("t5_hold2_cs", o_CS_L, 2'b01);
    tick();
    chk("t5_end_cs", o_CS_L, 2'b11);
    chk("t5_end_grant", o_Grant, 2'b00);

    // Reset in the middle of a byte, then a fresh burst
    i_Req = 2'b01;
    wait_grant(2'b01, 8, "t6_grant");
    tick();
    tick();
    i_DV = 2'b01; i_Byte_0 = 8'hC3; i_DC_0 = 1'b1;
    tick();
    i_DV = 2'b00;
    chk("t6_txdv", o_TX_DV, 1'b1);
    i_Rst_L = 1'b0;
    #1;
    chk("t6_rst_cs", o_CS_L, 2'b11);
    chk("t6_rst_grant", o_Grant, 2'b00);
    chk("t6_rst_txdv", o_TX_DV, 1'b0);
    tick();
    i_Rst_L = 1'b1;
    tick();
    chk("t6_regrant", o_Grant, 2'b01);
    chk("t6_recs", o_CS_L, 2'b10);
    tick();
    tick();
    send_byte(0, 8'h7E, 1'b1, 8'h24, "t6_b0");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
